irrigation_ctrl: RTL and testbench
==================================

IRRIGATION_CTRL -- requirements
Module: irrigation_ctrl

Interface
REQ-001 Parameter FILTER_LEN, default 4: clk1 cycles a raw sensor input must hold stable before its filtered value changes (range 2..15).
REQ-002 clk1  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 solo_seco  in  1  soil-dry sensor, 1 = dry.
REQ-005 ar_seco  in  1  air-humidity-low sensor, 1 = dry air.
REQ-006 temp_alta  in  1  high-temperature sensor.
REQ-007 nivel_baixo  in  1  water-tank-low sensor, 1 = insufficient water.
REQ-008 iniciar  in  1  start/resume request, level-sampled each cycle.
REQ-009 parar  in  1  stop/pause request, level-sampled each cycle.
REQ-010 timer_zero  in  1  countdown timer reads 00:00.
REQ-011 Gotejamento, Aspersao, Sespecifica  out  1 each  one-hot mode select to the countdown timer; all 0 when no mode.
REQ-012 buttom  out  1  timer load strobe, active-low; idle high.
REQ-013 Q21  out  1  timer run enable.
REQ-014 valvula_got, valvula_asp  out  1 each  drip / sprinkler valve drives.
REQ-015 alarme  out  1  tank-low fault indicator.
REQ-016 fim  out  1  one-cycle cycle-complete pulse.

Function
REQ-017 States: IDLE, LOAD, RUN, PAUSE, DONE, FAULT; all decisions use filtered sensor values only.
REQ-018 IDLE + iniciar: filtered nivel_baixo=1 -> FAULT; else solo_seco&ar_seco -> Aspersao; solo_seco&!ar_seco -> Gotejamento; !solo_seco&temp_alta -> Sespecifica; otherwise remain IDLE, outputs unchanged.
REQ-019 On mode selection, latch the one-hot mode and enter LOAD; mode outputs stay constant from LOAD through DONE.
REQ-020 LOAD lasts exactly one cycle with buttom=0; buttom is 1 in every other state; next state RUN.
REQ-021 RUN: Q21=1; valvula_got=Gotejamento|Sespecifica, valvula_asp=Aspersao; both valves 0 in all other states.
REQ-022 RUN -> DONE when timer_zero=1; timer_zero is ignored in LOAD and in the first RUN cycle.
REQ-023 RUN + parar -> PAUSE (Q21=0, valves 0, mode held); PAUSE + iniciar -> RUN without reload; PAUSE + parar -> IDLE, mode cleared.
REQ-024 Filtered nivel_baixo=1 in LOAD, RUN or PAUSE -> FAULT the next cycle, mode cleared; takes priority over all other events.
REQ-025 FAULT: alarme=1; exits to IDLE only when filtered nivel_baixo=0 and iniciar=1 in the same cycle.
REQ-026 DONE lasts one cycle with fim=1, mode cleared on exit, then IDLE.
REQ-027 iniciar and parar asserted together: parar wins in RUN/PAUSE; in IDLE neither acts.
REQ-028 Filter: per-input counter 0..FILTER_LEN-1; reset on raw==filtered, else increment; on reaching FILTER_LEN-1 with raw still different, filtered<=raw and counter cleared.

Reset
REQ-029 rst_n=0 at a clock edge: state IDLE, filtered values 0, filter counters 0, mode 0, buttom=1, Q21=0, valves 0, alarme=0, fim=0; reset mid-RUN drops Q21 and valves the following edge.

Configuration
REQ-030 IRRIGATION_SENSOR_FILTER_EN defined: REQ-028 filtering applies; undefined: filtered value = raw input registered one cycle, FILTER_LEN ignored.

Structure
REQ-031 Shared package irrigation_pkg holds the state encoding, the one-hot mode constants and FILTER_LEN default.
REQ-032 One sub-module sensor_filter (one instance per sensor input) implements REQ-028/REQ-030; FSM stays in irrigation_ctrl.

Verification
REQ-033 FILTER_LEN=4, solo_seco=1, ar_seco=1 held 5 cycles, iniciar pulse -> Aspersao=1, buttom=0 one cycle, then Q21=1, valvula_asp=1.
REQ-034 RUN in Gotejamento, timer_zero=1 -> fim=1 one cycle, Gotejamento=0, Q21=0, state IDLE.
REQ-035 nivel_baixo=1 for 3 cycles then 0 during RUN -> no fault; held 4 cycles -> alarme=1, valves 0; later nivel_baixo=0 held 4 cycles + iniciar -> IDLE, alarme=0.
REQ-036 RUN, parar=1 -> PAUSE, Q21=0, mode held; iniciar -> RUN, buttom stays 1 (no reload).
REQ-037 iniciar=parar=1 in RUN -> PAUSE; rst_n=0 mid-RUN -> all outputs at reset values next edge.
REQ-038 Macro undefined: single-cycle solo_seco glitch plus iniciar in the next cycle -> mode selected (filter bypassed).

Source files
------------

// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state encoding, mode constants and helpers for irrigation_ctrl
package irrigation_pkg;

    localparam int FILTER_LEN_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    // One-hot mode word, bit order {Gotejamento, Aspersao, Sespecifica}
    localparam logic [2:0] MODE_NONE = 3'b000;
    localparam logic [2:0] MODE_GOT  = 3'b100;
    localparam logic [2:0] MODE_ASP  = 3'b010;
    localparam logic [2:0] MODE_ESP  = 3'b001;

    // The special mode waters through the drip line as well
    function automatic logic valve_got_of(input logic [2:0] mode);
        return mode[2] | mode[0];
    endfunction

    function automatic logic valve_asp_of(input logic [2:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/irrigation_ctrl_sensor_filter.sv
// rtl/irrigation_ctrl_sensor_filter.sv - debounce filter for one raw sensor input
//
// Ports: clk1, rst_n (sync active-low), raw (sensor input), filt (filtered value).
// Macro IRRIGATION_SENSOR_FILTER_EN: defined -> raw must hold a new value for
// FILTER_LEN cycles before filt follows; undefined -> filt is raw registered once.
module sensor_filter
    import irrigation_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_len_check
        $error("sensor_filter: FILTER_LEN out of range 2..15");
    end

`ifdef IRRIGATION_SENSOR_FILTER_EN
    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= 4'd0;
        end else if (raw == filt) begin
            cnt <= 4'd0;
        end else if (cnt == CNT_MAX) begin
            filt <= raw;
            cnt  <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end
`else
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            filt <= 1'b0;
        end else begin
            filt <= raw;
        end
    end
`endif

endmodule

// File: rtl/irrigation_ctrl.sv
// rtl/irrigation_ctrl.sv - irrigation cycle controller driving a countdown timer and two valves
//
// Ports: clk1, rst_n (sync active-low); sensors solo_seco, ar_seco, temp_alta,
// nivel_baixo; requests iniciar, parar; timer_zero from the timer.
// Outputs: one-hot mode Gotejamento/Aspersao/Sespecifica, buttom (active-low load),
// Q21 (timer run), valvula_got, valvula_asp, alarme, fim.
// Macro IRRIGATION_SENSOR_FILTER_EN selects debounced sensor filtering.
module irrigation_ctrl
    import irrigation_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic solo_seco,
    input  logic ar_seco,
    input  logic temp_alta,
    input  logic nivel_baixo,
    input  logic iniciar,
    input  logic parar,
    input  logic timer_zero,
    output logic Gotejamento,
    output logic Aspersao,
    output logic Sespecifica,
    output logic buttom,
    output logic Q21,
    output logic valvula_got,
    output logic valvula_asp,
    output logic alarme,
    output logic fim
);

    logic [3:0] raw_vec;
    logic [3:0] flt_vec;
    logic       f_solo, f_ar, f_temp, f_nivel;

    assign raw_vec = {solo_seco, ar_seco, temp_alta, nivel_baixo};
    assign {f_solo, f_ar, f_temp, f_nivel} = flt_vec;

    for (genvar i = 0; i < 4; i++) begin : g_filt
        sensor_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk1 (clk1),
            .rst_n(rst_n),
            .raw  (raw_vec[i]),
            .filt (flt_vec[i])
        );
    end

    state_t     state;
    logic [2:0] mode;
    logic       first_run;  // timer_zero is stale on the first RUN cycle after a load

    assign {Gotejamento, Aspersao, Sespecifica} = mode;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode        <= MODE_NONE;
            first_run   <= 1'b0;
            buttom      <= 1'b1;
            Q21         <= 1'b0;
            valvula_got <= 1'b0;
            valvula_asp <= 1'b0;
            alarme      <= 1'b0;
            fim         <= 1'b0;
        end else begin
            buttom <= 1'b1;
            fim    <= 1'b0;
            // Tank-low pre-empts every other event while a cycle is active
            if (f_nivel && (state == ST_LOAD || state == ST_RUN || state == ST_PAUSE)) begin
                state       <= ST_FAULT;
                mode        <= MODE_NONE;
                first_run   <= 1'b0;
                Q21         <= 1'b0;
                valvula_got <= 1'b0;
                valvula_asp <= 1'b0;
                alarme      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (iniciar && !parar) begin
                            if (f_nivel) begin
                                state  <= ST_FAULT;
                                alarme <= 1'b1;
                            end else if (f_solo && f_ar) begin
                                mode   <= MODE_ASP;
                                state  <= ST_LOAD;
                                buttom <= 1'b0;
                            end else if (f_solo) begin
                                mode   <= MODE_GOT;
                                state  <= ST_LOAD;
                                buttom <= 1'b0;
                            end else if (f_temp) begin
                                mode   <= MODE_ESP;
                                state  <= ST_LOAD;
                                buttom <= 1'b0;
                            end
                        end
                    end
                    ST_LOAD: begin
                        state       <= ST_RUN;
                        first_run   <= 1'b1;
                        Q21         <= 1'b1;
                        valvula_got <= valve_got_of(mode);
                        valvula_asp <= valve_asp_of(mode);
                    end
                    ST_RUN: begin
                        first_run <= 1'b0;
                        if (parar) begin
                            state       <= ST_PAUSE;
                            Q21         <= 1'b0;
                            valvula_got <= 1'b0;
                            valvula_asp <= 1'b0;
                        end else if (timer_zero && !first_run) begin
                            state       <= ST_DONE;
                            fim         <= 1'b1;
                            Q21         <= 1'b0;
                            valvula_got <= 1'b0;
                            valvula_asp <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (parar) begin
                            state <= ST_IDLE;
                            mode  <= MODE_NONE;
                        end else if (iniciar) begin
                            state       <= ST_RUN;
                            Q21         <= 1'b1;
                            valvula_got <= valve_got_of(mode);
                            valvula_asp <= valve_asp_of(mode);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        mode  <= MODE_NONE;
                    end
                    ST_FAULT: begin
                        if (!f_nivel && iniciar) begin
                            state  <= ST_IDLE;
                            alarme <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        mode  <= MODE_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irrigation_ctrl.sv
// tb/tb_irrigation_ctrl.sv - directed self-checking bench for irrigation_ctrl
module tb_irrigation_ctrl;

`ifdef IRRIGATION_SENSOR_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif

    logic clk1 = 1'b0;
    logic rst_n, solo_seco, ar_seco, temp_alta, nivel_baixo, iniciar, parar, timer_zero;
    logic Gotejamento, Aspersao, Sespecifica, buttom, Q21, valvula_got, valvula_asp, alarme, fim;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk1 = ~clk1;

    irrigation_ctrl #(.FILTER_LEN(4)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .solo_seco  (solo_seco),
        .ar_seco    (ar_seco),
        .temp_alta  (temp_alta),
        .nivel_baixo(nivel_baixo),
        .iniciar    (iniciar),
        .parar      (parar),
        .timer_zero (timer_zero),
        .Gotejamento(Gotejamento),
        .Aspersao   (Aspersao),
        .Sespecifica(Sespecifica),
        .buttom     (buttom),
        .Q21        (Q21),
        .valvula_got(valvula_got),
        .valvula_asp(valvula_asp),
        .alarme     (alarme),
        .fim        (fim)
    );

    logic [8:0] outs;
    assign outs = {Gotejamento, Aspersao, Sespecifica, buttom, Q21,
                   valvula_got, valvula_asp, alarme, fim};

    // Expected output word: {mode[2:0], buttom, Q21, vg, va, alarme, fim}
    function automatic logic [8:0] o(input logic [2:0] m, input logic b, input logic q,
                                     input logic vg, input logic va, input logic al,
                                     input logic fi);
        return {m, b, q, vg, va, al, fi};
    endfunction

    localparam logic [8:0] O_IDLE = 9'b000_1_0_0_0_0_0;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; solo_seco = 1'b0; ar_seco = 1'b0; temp_alta = 1'b0;
        nivel_baixo = 1'b0; iniciar = 1'b0; parar = 1'b0; timer_zero = 1'b0;
        tick(2);
        check("reset", outs, O_IDLE);
        rst_n = 1'b1;

        // Aspersao cycle; timer_zero held from IDLE onward must be ignored in LOAD and first RUN
        solo_seco = 1'b1; ar_seco = 1'b1;
        tick(LAT + 1);
        check("idle_no_req", outs, O_IDLE);
        iniciar = 1'b1; timer_zero = 1'b1;
        tick();
        iniciar = 1'b0;
        check("asp_load", outs, o(3'b010, 0, 0, 0, 0, 0, 0));
        tick();
        check("asp_run", outs, o(3'b010, 1, 1, 0, 1, 0, 0));
        tick();
        check("asp_run_first_ignored", outs, o(3'b010, 1, 1, 0, 1, 0, 0));
        tick();
        check("asp_done", outs, o(3'b010, 1, 0, 0, 0, 0, 1));
        timer_zero = 1'b0;
        tick();
        check("asp_idle", outs, O_IDLE);

        // Gotejamento cycle ending on timer_zero
        ar_seco = 1'b0;
        tick(LAT);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("got_load", outs, o(3'b100, 0, 0, 0, 0, 0, 0));
        tick(2);
        check("got_run", outs, o(3'b100, 1, 1, 1, 0, 0, 0));
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        check("got_done", outs, o(3'b100, 1, 0, 0, 0, 0, 1));
        tick();
        check("got_idle", outs, O_IDLE);

        // Pause / resume without reload, both-request priority
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        parar = 1'b1;
        tick();
        parar = 1'b0;
        check("pause", outs, o(3'b100, 1, 0, 0, 0, 0, 0));
        tick();
        check("pause_hold", outs, o(3'b100, 1, 0, 0, 0, 0, 0));
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("resume_no_reload", outs, o(3'b100, 1, 1, 1, 0, 0, 0));
        iniciar = 1'b1; parar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("both_in_run", outs, o(3'b100, 1, 0, 0, 0, 0, 0));
        tick();
        parar = 1'b0;
        check("pause_stop", outs, O_IDLE);
        iniciar = 1'b1; parar = 1'b1;
        tick();
        iniciar = 1'b0; parar = 1'b0;
        check("both_in_idle", outs, O_IDLE);

        // Tank-low during RUN
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
`ifdef IRRIGATION_SENSOR_FILTER_EN
        nivel_baixo = 1'b1;
        tick(3);
        nivel_baixo = 1'b0;
        tick(2);
        check("nivel_glitch", outs, o(3'b100, 1, 1, 1, 0, 0, 0));
`endif
        nivel_baixo = 1'b1;
        tick(LAT);
        check("nivel_settling", outs, o(3'b100, 1, 1, 1, 0, 0, 0));
        tick();
        check("fault", outs, o(3'b000, 1, 0, 0, 0, 1, 0));
        nivel_baixo = 1'b0; iniciar = 1'b1;
        tick(LAT);
        check("fault_hold", outs, o(3'b000, 1, 0, 0, 0, 1, 0));
        tick();
        iniciar = 1'b0;
        check("fault_exit", outs, O_IDLE);

        // Tank-low seen from IDLE
        nivel_baixo = 1'b1;
        tick(LAT);
        iniciar = 1'b1;
        tick();
        check("fault_from_idle", outs, o(3'b000, 1, 0, 0, 0, 1, 0));
        tick(2);
        check("fault_needs_level_ok", outs, o(3'b000, 1, 0, 0, 0, 1, 0));
        nivel_baixo = 1'b0;
        tick(LAT + 1);
        iniciar = 1'b0;
        check("fault_exit2", outs, O_IDLE);

        // Sespecifica cycle, then reset mid-RUN
        solo_seco = 1'b0; temp_alta = 1'b1;
        tick(LAT);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("esp_load", outs, o(3'b001, 0, 0, 0, 0, 0, 0));
        tick();
        check("esp_run", outs, o(3'b001, 1, 1, 1, 0, 0, 0));
        rst_n = 1'b0; temp_alta = 1'b0;
        tick();
        check("reset_mid_run", outs, O_IDLE);
        rst_n = 1'b1;
        tick();

        // Single-cycle solo_seco glitch then start request
        solo_seco = 1'b1;
        tick();
        solo_seco = 1'b0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
`ifdef IRRIGATION_SENSOR_FILTER_EN
        check("glitch_filtered", outs, O_IDLE);
`else
        check("glitch_bypass", outs, o(3'b100, 0, 0, 0, 0, 0, 0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
